// File: rtl/chess_pkg.sv
// chess_pkg: shared constants and types for board evaluation.
//   - piece codes are magnitudes; a signed code's sign gives colour
//   - weights are centipawn material values
//   - state_e is the board_eval sequencer state
package chess_pkg;

  localparam int MAX_BOARDS = 255;
  localparam int SQUARES    = 64;

  localparam logic [7:0] EMPTY  = 8'd0;
  localparam logic [7:0] PAWN   = 8'd1;
  localparam logic [7:0] KNIGHT = 8'd2;
  localparam logic [7:0] BISHOP = 8'd3;
  localparam logic [7:0] ROOK   = 8'd4;
  localparam logic [7:0] QUEEN  = 8'd5;
  localparam logic [7:0] KING   = 8'd6;

  localparam logic signed [7:0] WHITE = 8'sd1;
  localparam logic signed [7:0] BLACK = -8'sd1;

  localparam logic signed [31:0] W_PAWN   = 32'sd100;
  localparam logic signed [31:0] W_KNIGHT = 32'sd320;
  localparam logic signed [31:0] W_BISHOP = 32'sd330;
  localparam logic signed [31:0] W_ROOK   = 32'sd500;
  localparam logic signed [31:0] W_QUEEN  = 32'sd900;
  localparam logic signed [31:0] W_KING   = 32'sd20000;

  localparam logic [31:0] NO_BEST = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_DONE
  } state_e;

endpackage

// File: rtl/board_eval_if.sv
// board_eval_if: CPU register port (slave_*) and SDRAM port (master_*).
//   modport slave  : the evaluator's view (answers the CPU, drives SDRAM requests)
//   modport master : the system's view (CPU + SDRAM controller)
interface board_eval_if;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;

  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;

  modport slave (
    output slave_waitrequest, slave_readdata,
    input  slave_address, slave_read, slave_write, slave_writedata,
    input  master_waitrequest, master_readdata, master_readdatavalid,
    output master_address, master_read, master_write, master_writedata
  );

  modport master (
    input  slave_waitrequest, slave_readdata,
    output slave_address, slave_read, slave_write, slave_writedata,
    output master_waitrequest, master_readdata, master_readdatavalid,
    input  master_address, master_read, master_write, master_writedata
  );
endinterface

// File: rtl/piece_value.sv
// piece_value: signed material contribution of one square.
//   code_i  : signed 8-bit piece code (positive white, negative black)
//   value_o : +weight for white, -weight for black, 0 for empty/unknown
module piece_value
  import chess_pkg::*;
(
  input  logic signed [7:0]  code_i,
  output logic signed [31:0] value_o
);

  logic [7:0]         mag;
  logic signed [31:0] weight;

  always_comb begin
    // -128 has magnitude 128 and falls into the zero-weight default
    mag = code_i[7] ? (~code_i + 8'd1) : code_i;
    case (mag)
      PAWN:    weight = W_PAWN;
      KNIGHT:  weight = W_KNIGHT;
      BISHOP:  weight = W_BISHOP;
      ROOK:    weight = W_ROOK;
      QUEEN:   weight = W_QUEEN;
      KING:    weight = W_KING;
      default: weight = 32'sd0;
    endcase
    value_o = code_i[7] ? -weight : weight;
  end

endmodule

// File: rtl/board_eval.sv
// board_eval: reads N 64-square boards from SDRAM, writes one material score
// per board to a result array and tracks the best board for the side to move.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : board_eval_if.slave (CPU registers + SDRAM master)
//
// state      | meaning
// ST_IDLE    | waiting for configuration / start
// ST_RD_REQ  | read request for square s of board i held until accepted
// ST_RD_WAIT | waiting for the read data, accumulating
// ST_WR_REQ  | writing board i's score to dest+i, updating best
// ST_DONE    | job finished, results readable, may be restarted
module board_eval
  import chess_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  board_eval_if.slave  bus
);

  state_e             state_q, state_d;
  logic [31:0]        src_q, src_d, dest_q, dest_d;
  logic [7:0]         count_q, count_d, i_q, i_d;
  logic [5:0]         s_q, s_d;
  logic               side_q, side_d;
  logic signed [31:0] acc_q, acc_d, best_score_q, best_score_d;
  logic [31:0]        best_idx_q, best_idx_d, boards_done_q, boards_done_d;
  logic               waitreq_q;

  logic               cfg_wr, better, busy, done;
  logic signed [31:0] piece_val;
  logic               unused_rdata_hi;

  piece_value u_piece_value (
    .code_i  (bus.master_readdata[7:0]),
    .value_o (piece_val)
  );

  assign unused_rdata_hi = ^bus.master_readdata[31:8];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      src_q         <= '0;
      dest_q        <= '0;
      count_q       <= '0;
      side_q        <= 1'b0;
      i_q           <= '0;
      s_q           <= '0;
      acc_q         <= '0;
      best_score_q  <= '0;
      best_idx_q    <= NO_BEST;
      boards_done_q <= '0;
      waitreq_q     <= 1'b1;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      dest_q        <= dest_d;
      count_q       <= count_d;
      side_q        <= side_d;
      i_q           <= i_d;
      s_q           <= s_d;
      acc_q         <= acc_d;
      best_score_q  <= best_score_d;
      best_idx_q    <= best_idx_d;
      boards_done_q <= boards_done_d;
      waitreq_q     <= 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    dest_d        = dest_q;
    count_d       = count_q;
    side_d        = side_q;
    i_d           = i_q;
    s_d           = s_q;
    acc_d         = acc_q;
    best_score_d  = best_score_q;
    best_idx_d    = best_idx_q;
    boards_done_d = boards_done_q;

    cfg_wr = bus.slave_write && (state_q == ST_IDLE || state_q == ST_DONE);
    better = (best_idx_q == NO_BEST) ||
             (side_q ? (acc_q < best_score_q) : (acc_q > best_score_q));

    // An 8-bit count field cannot exceed MAX_BOARDS, so no extra clamp.
    if (cfg_wr) begin
      case (bus.slave_address)
        4'd1:    src_d   = bus.slave_writedata;
        4'd2:    count_d = bus.slave_writedata[7:0];
        4'd3:    dest_d  = bus.slave_writedata;
        4'd4:    side_d  = bus.slave_writedata[0];
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cfg_wr && bus.slave_address == 4'd0) begin
          acc_d         = '0;
          i_d           = '0;
          s_d           = '0;
          boards_done_d = '0;
          best_idx_d    = NO_BEST;
          best_score_d  = '0;
          state_d       = (count_q == 8'd0) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (!bus.master_waitrequest) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (bus.master_readdatavalid) begin
          acc_d = acc_q + piece_val;
          if (s_q == 6'(SQUARES - 1)) begin
            state_d = ST_WR_REQ;
          end else begin
            s_d     = s_q + 6'd1;
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        if (!bus.master_waitrequest) begin
          if (better) begin
            best_idx_d   = {24'd0, i_q};
            best_score_d = acc_q;
          end
          boards_done_d = boards_done_q + 32'd1;
          acc_d         = '0;
          s_d           = '0;
          i_d           = i_q + 8'd1;
          state_d = ({1'b0, i_q} + 9'd1 == {1'b0, count_q}) ? ST_DONE : ST_RD_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT) || (state_q == ST_WR_REQ);
  assign done = (state_q == ST_DONE);

  // Requests are gated by rst_n so a reset drops them in the cycle it is applied.
  assign bus.master_read      = rst_n && (state_q == ST_RD_REQ);
  assign bus.master_write     = rst_n && (state_q == ST_WR_REQ);
  assign bus.master_address   = bus.master_read  ? (src_q + {18'd0, i_q, 6'd0} + {26'd0, s_q}) :
                                bus.master_write ? (dest_q + {24'd0, i_q}) : 32'd0;
  assign bus.master_writedata = bus.master_write ? acc_q : 32'd0;

  assign bus.slave_waitrequest = waitreq_q;

  always_comb begin
    bus.slave_readdata = 32'd0;
    if (bus.slave_read && rst_n) begin
      case (bus.slave_address)
        4'd0:    bus.slave_readdata = {30'd0, done, busy};
        4'd1:    bus.slave_readdata = best_idx_q;
        4'd2:    bus.slave_readdata = best_score_q;
        4'd3:    bus.slave_readdata = boards_done_q;
        default: bus.slave_readdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_board_eval.sv
module tb_board_eval;
  import chess_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  board_eval_if bus ();

  board_eval dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [logic [31:0]];
  int  errors = 0;
  int  checks = 0;
  bit  stall_en = 1'b0;
  bit  any_rd = 1'b0, any_wr = 1'b0, both_seen = 1'b0;

  typedef struct {
    logic [31:0] src;
    logic [7:0]  cnt;
    logic [31:0] dest;
    logic        side;
    bit          stall;
    logic [31:0] exp_idx;
    logic [31:0] exp_score;
    logic [31:0] s0, s1, s2;
  } job_t;

  job_t jobs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic signed [7:0] start_code(input int sq);
    int row, col;
    logic signed [7:0] back;
    row = sq / 8;
    col = sq % 8;
    case (col)
      0, 7:    back = 8'sd4;
      1, 6:    back = 8'sd2;
      2, 5:    back = 8'sd3;
      3:       back = 8'sd5;
      default: back = 8'sd6;
    endcase
    if (row == 0)      return back;
    else if (row == 1) return 8'sd1;
    else if (row == 6) return -8'sd1;
    else if (row == 7) return -back;
    return 8'sd0;
  endfunction

  // kind: 0 start, 1 +white pawn (plus zero-weight odd codes), 2 +white rook,
  // 3 +black rook, 4 +white queen, 5 black king missing
  task automatic load_board(input logic [31:0] base, input int kind);
    logic signed [7:0] c;
    for (int sq = 0; sq < 64; sq++) begin
      c = start_code(sq);
      case (kind)
        1: begin
          if (sq == 16) c = 8'sd1;
          if (sq == 20) c = -8'sd128;
          if (sq == 21) c = 8'sd7;
          if (sq == 22) c = -8'sd7;
        end
        2: if (sq == 16) c = 8'sd4;
        3: if (sq == 40) c = -8'sd4;
        4: if (sq == 16) c = 8'sd5;
        5: if (sq == 60) c = 8'sd0;
        default: ;
      endcase
      mem[base + 32'(sq)] = {24'hC3A500 ^ 24'(sq * 37), c};
    end
  endtask

  // SDRAM model: decides waitrequest/readdatavalid at negedge for the next posedge.
  initial begin
    int pend;
    int stall_cnt;
    logic [31:0] pend_addr;
    pend = 0;
    stall_cnt = 0;
    pend_addr = '0;
    bus.master_waitrequest   = 1'b0;
    bus.master_readdatavalid = 1'b0;
    bus.master_readdata      = 32'h7777_7777;
    forever begin
      @(negedge clk);
      if (bus.master_read && bus.master_write) both_seen = 1'b1;
      if (bus.master_read)  any_rd = 1'b1;
      if (bus.master_write) any_wr = 1'b1;
      bus.master_readdatavalid = 1'b0;
      bus.master_readdata      = 32'h7777_7777;
      if (!rst_n) begin
        pend = 0;
        bus.master_waitrequest = 1'b0;
        continue;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.master_readdatavalid = 1'b1;
          bus.master_readdata = mem.exists(pend_addr) ? mem[pend_addr] : 32'd0;
        end
      end
      if (stall_en && stall_cnt < 5 && $urandom_range(0, 1) == 1) begin
        bus.master_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        bus.master_waitrequest = 1'b0;
        stall_cnt = 0;
      end
      if (bus.master_read && !bus.master_waitrequest) begin
        pend_addr = bus.master_address;
        pend = stall_en ? int'($urandom_range(1, 4)) : 1;
      end
      if (bus.master_write && !bus.master_waitrequest)
        mem[bus.master_address] = bus.master_writedata;
    end
  end

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.slave_address   = a;
    bus.slave_writedata = d;
    bus.slave_write     = 1'b1;
    @(negedge clk);
    bus.slave_write     = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.slave_address = a;
    bus.slave_read    = 1'b1;
    #1 d = bus.slave_readdata;
    bus.slave_read    = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    logic [31:0] st;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      cpu_read(4'd0, st);
      if (st[1]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_job(input job_t j);
    cpu_write(4'd1, j.src);
    cpu_write(4'd2, {24'd0, j.cnt});
    cpu_write(4'd3, j.dest);
    cpu_write(4'd4, {31'd0, j.side});
    cpu_write(4'd0, 32'd0);
  endtask

  task automatic run_job(input int idx, input job_t j);
    bit ok;
    logic [31:0] v;
    logic [31:0] exp_s [3];
    exp_s[0] = j.s0; exp_s[1] = j.s1; exp_s[2] = j.s2;
    for (int k = 0; k < int'(j.cnt); k++) mem[j.dest + 32'(k)] = 32'hDEAD_BEEF;
    stall_en = j.stall;
    start_job(j);
    wait_done(int'(j.cnt) * 64 * 16 + 50, ok);
    check($sformatf("job%0d_done_in_time", idx), {31'd0, ok}, 32'd1);
    cpu_read(4'd0, v); check($sformatf("job%0d_status", idx), v, 32'd2);
    cpu_read(4'd1, v); check($sformatf("job%0d_best_idx", idx), v, j.exp_idx);
    cpu_read(4'd2, v); check($sformatf("job%0d_best_score", idx), v, j.exp_score);
    cpu_read(4'd3, v); check($sformatf("job%0d_boards_done", idx), v, {24'd0, j.cnt});
    for (int k = 0; k < int'(j.cnt); k++)
      check($sformatf("job%0d_score%0d", idx, k), mem[j.dest + 32'(k)], exp_s[k]);
    stall_en = 1'b0;
  endtask

  function automatic job_t mk(input logic [31:0] src, input logic [7:0] cnt, input logic [31:0] dest,
                              input logic side, input bit stall, input logic [31:0] idx,
                              input int score, input int s0, input int s1, input int s2);
    job_t j;
    j.src = src; j.cnt = cnt; j.dest = dest; j.side = side; j.stall = stall;
    j.exp_idx = idx; j.exp_score = 32'(score);
    j.s0 = 32'(s0); j.s1 = 32'(s1); j.s2 = 32'(s2);
    return j;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    bit found;
    bus.slave_address   = '0;
    bus.slave_read      = 1'b0;
    bus.slave_write     = 1'b0;
    bus.slave_writedata = '0;

    load_board(32'h1000, 0);
    load_board(32'h3000, 1);
    load_board(32'h3040, 2);
    load_board(32'h3080, 3);
    load_board(32'h5000, 4);
    load_board(32'h5040, 4);
    load_board(32'h7000, 5);

    jobs[0] = mk(32'h1000, 8'd1, 32'h2000, 1'b0, 1'b0, 32'd0, 0,     0,     0,    0);
    jobs[1] = mk(32'h3000, 8'd3, 32'h4000, 1'b0, 1'b0, 32'd1, 500,   100,   500,  -500);
    jobs[2] = mk(32'h3000, 8'd3, 32'h4100, 1'b1, 1'b0, 32'd2, -500,  100,   500,  -500);
    jobs[3] = mk(32'h5000, 8'd2, 32'h6000, 1'b0, 1'b0, 32'd0, 900,   900,   900,  0);
    jobs[4] = mk(32'h7000, 8'd1, 32'h8000, 1'b1, 1'b0, 32'd0, 20000, 20000, 0,    0);
    jobs[5] = mk(32'h3000, 8'd3, 32'h4200, 1'b0, 1'b1, 32'd1, 500,   100,   500,  -500);
    jobs[6] = mk(32'h3000, 8'd3, 32'h4300, 1'b1, 1'b1, 32'd2, -500,  100,   500,  -500);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_waitrequest", {31'd0, bus.slave_waitrequest}, 32'd1);
    check("rst_master_read", {31'd0, bus.master_read}, 32'd0);
    check("rst_master_write", {31'd0, bus.master_write}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_waitrequest", {31'd0, bus.slave_waitrequest}, 32'd0);
    cpu_read(4'd0, v); check("rst_status", v, 32'd0);
    cpu_read(4'd1, v); check("rst_best_idx", v, 32'hFFFF_FFFF);
    cpu_read(4'd2, v); check("rst_best_score", v, 32'd0);
    cpu_read(4'd3, v); check("rst_boards_done", v, 32'd0);
    cpu_read(4'd9, v); check("unmapped_read", v, 32'd0);

    for (int n = 0; n < 7; n++) run_job(n, jobs[n]);

    // count = 0: done right after the start edge, no SDRAM traffic
    any_rd = 1'b0;
    any_wr = 1'b0;
    cpu_write(4'd2, 32'd0);
    cpu_write(4'd0, 32'd0);
    bus.slave_address = 4'd0;
    bus.slave_read    = 1'b1;
    #1 v = bus.slave_readdata;
    bus.slave_read    = 1'b0;
    check("cnt0_status", v, 32'd2);
    repeat (20) @(negedge clk);
    check("cnt0_no_read", {31'd0, any_rd}, 32'd0);
    check("cnt0_no_write", {31'd0, any_wr}, 32'd0);
    cpu_read(4'd1, v); check("cnt0_best_idx", v, 32'hFFFF_FFFF);
    cpu_read(4'd3, v); check("cnt0_boards_done", v, 32'd0);

    // Reset in the middle of a board
    stall_en = 1'b1;
    start_job(mk(32'h3000, 8'd3, 32'h4400, 1'b0, 1'b1, 32'd1, 500, 100, 500, -500));
    repeat (100) @(negedge clk);
    found = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (bus.master_read) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("midrst_read_seen", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_read_drop", {31'd0, bus.master_read}, 32'd0);
    check("midrst_write_drop", {31'd0, bus.master_write}, 32'd0);
    @(posedge clk);
    #1;
    check("midrst_read_after_edge", {31'd0, bus.master_read}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stall_en = 1'b0;
    @(negedge clk);
    cpu_read(4'd0, v); check("midrst_status", v, 32'd0);
    cpu_read(4'd1, v); check("midrst_best_idx", v, 32'hFFFF_FFFF);
    run_job(7, jobs[1]);

    check("rd_wr_exclusive", {31'd0, both_seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
